// File: rtl/ifetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, drives a one-cycle-latency instruction memory
// and presents the IF/ID slot to decode, honouring stalls and squashing after redirects.
module ifetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_id,
    output logic [31:0] instr_id,
    output logic        valid_id
);

    localparam logic [1:0] StBoot  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StHold  = 2'd2;
    localparam logic [1:0] StFlush = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] pc_id_q, pc_id_d;
    logic [31:0] hold_q, hold_d;
    logic        stl;

    // Target low bits are forced to zero, so they are deliberately unused.
    logic unused_rpc_lsb;
    assign unused_rpc_lsb = ^redirect_pc[1:0];

    // A stall is meaningless while the slot holds a bubble.
    assign stl = stall & valid_id;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        pc_id_d    = pc_id_q;
        hold_d     = hold_q;
        if (redirect) begin
            state_d    = StFlush;
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
        end else if (stl) begin
            state_d = StHold;
            if (state_q == StRun) begin
                hold_d = imem_rdata;
            end
        end else begin
            state_d    = StRun;
            pc_id_d    = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StBoot;
            fetch_pc_q <= RESET_PC;
            pc_id_q    <= RESET_PC;
            hold_q     <= NOP_INSTR;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pc_id_q    <= pc_id_d;
            hold_q     <= hold_d;
        end
    end

    always_comb begin
        valid_id = 1'b0;
        instr_id = NOP_INSTR;
        case (state_q)
            StRun: begin
                valid_id = 1'b1;
                instr_id = imem_rdata;
            end
            StHold: begin
                valid_id = 1'b1;
                instr_id = hold_q;
            end
            default: begin
                valid_id = 1'b0;
                instr_id = NOP_INSTR;
            end
        endcase
    end

    assign imem_en   = rst_n;
    assign imem_addr = fetch_pc_q;
    assign pc_id     = pc_id_q;

endmodule

// File: tb/tb_ifetch_stage.sv
// Directed, table-driven bench for ifetch_stage with a behavioural one-cycle-latency memory.
module tb_ifetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, redirect;
    logic [31:0] redirect_pc;
    logic        imem_en, valid_id;
    logic [31:0] imem_addr, imem_rdata, pc_id, instr_id;

    logic        imem_en2, valid_id2;
    logic [31:0] imem_addr2, imem_rdata2, pc_id2, instr_id2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ifetch_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_en(imem_en), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .pc_id(pc_id), .instr_id(instr_id), .valid_id(valid_id)
    );

    // Second instance checks PC wrap from the top of the address space.
    ifetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .stall(1'b0), .redirect(1'b0),
        .redirect_pc(32'h0), .imem_en(imem_en2), .imem_addr(imem_addr2),
        .imem_rdata(imem_rdata2), .pc_id(pc_id2), .instr_id(instr_id2), .valid_id(valid_id2)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return {~a[15:0], a[15:0]};
    endfunction

    initial begin
        imem_rdata  = 32'h0;
        imem_rdata2 = 32'h0;
    end
    always @(posedge clk) if (imem_en) imem_rdata <= mem_word(imem_addr);
    always @(posedge clk) if (imem_en2) imem_rdata2 <= mem_word(imem_addr2);

    typedef struct packed {
        logic        rst_n;
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] addr;
        logic        en;
    } vec_t;

    localparam int NVec = 25;
    vec_t vecs [NVec];

    function automatic vec_t mk(input logic r, input logic s, input logic d,
                                input logic [31:0] rpc, input logic v, input logic [31:0] pc,
                                input logic [31:0] ins, input logic [31:0] ad, input logic en);
        vec_t x;
        x.rst_n = r; x.stall = s; x.redir = d; x.rpc = rpc;
        x.valid = v; x.pc = pc; x.instr = ins; x.addr = ad; x.en = en;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_slot(input string tag, input logic v, input logic [31:0] pc,
                            input logic [31:0] ins, input logic [31:0] ad, input logic en);
        chk({tag, " valid_id"}, {31'b0, valid_id}, {31'b0, v});
        chk({tag, " pc_id"}, pc_id, pc);
        chk({tag, " instr_id"}, instr_id, ins);
        chk({tag, " imem_addr"}, imem_addr, ad);
        chk({tag, " imem_en"}, {31'b0, imem_en}, {31'b0, en});
    endtask

    task automatic drive(input logic r, input logic s, input logic d, input logic [31:0] rpc);
        @(negedge clk);
        rst_n = r; stall = s; redirect = d; redirect_pc = rpc;
        #1;
    endtask

    initial begin
        //                 rst stl red  rpc           valid pc            instr               addr          en
        vecs[0]  = mk(1'b0, 0, 0, 32'h0,   0, 32'h0,   32'h13,            32'h0,        0);
        vecs[1]  = mk(1'b0, 0, 0, 32'h0,   0, 32'h0,   32'h13,            32'h0,        0);
        vecs[2]  = mk(1'b1, 0, 0, 32'h0,   0, 32'h0,   32'h13,            32'h0,        1);
        vecs[3]  = mk(1'b1, 0, 0, 32'h0,   1, 32'h0,   32'h0050_0093,     32'h4,        1);
        vecs[4]  = mk(1'b1, 0, 0, 32'h0,   1, 32'h4,   mem_word(32'h4),   32'h8,        1);
        vecs[5]  = mk(1'b1, 1, 0, 32'h0,   1, 32'h8,   mem_word(32'h8),   32'hC,        1);
        vecs[6]  = mk(1'b1, 1, 0, 32'h0,   1, 32'h8,   mem_word(32'h8),   32'hC,        1);
        vecs[7]  = mk(1'b1, 1, 0, 32'h0,   1, 32'h8,   mem_word(32'h8),   32'hC,        1);
        vecs[8]  = mk(1'b1, 0, 0, 32'h0,   1, 32'h8,   mem_word(32'h8),   32'hC,        1);
        vecs[9]  = mk(1'b1, 0, 0, 32'h0,   1, 32'hC,   mem_word(32'hC),   32'h10,       1);
        vecs[10] = mk(1'b1, 0, 1, 32'h103, 1, 32'h10,  mem_word(32'h10),  32'h14,       1);
        vecs[11] = mk(1'b1, 1, 0, 32'h0,   0, 32'h10,  32'h13,            32'h100,      1);
        vecs[12] = mk(1'b1, 1, 0, 32'h0,   1, 32'h100, mem_word(32'h100), 32'h104,      1);
        vecs[13] = mk(1'b1, 1, 1, 32'h200, 1, 32'h100, mem_word(32'h100), 32'h104,      1);
        vecs[14] = mk(1'b1, 0, 0, 32'h0,   0, 32'h100, 32'h13,            32'h200,      1);
        vecs[15] = mk(1'b1, 0, 1, 32'h300, 1, 32'h200, mem_word(32'h200), 32'h204,      1);
        vecs[16] = mk(1'b1, 0, 1, 32'h400, 0, 32'h200, 32'h13,            32'h300,      1);
        vecs[17] = mk(1'b1, 0, 0, 32'h0,   0, 32'h200, 32'h13,            32'h400,      1);
        vecs[18] = mk(1'b1, 0, 1, 32'h3C,  1, 32'h400, mem_word(32'h400), 32'h404,      1);
        vecs[19] = mk(1'b1, 0, 0, 32'h0,   0, 32'h400, 32'h13,            32'h3C,       1);
        vecs[20] = mk(1'b1, 0, 0, 32'h0,   1, 32'h3C,  mem_word(32'h3C),  32'h40,       1);
        vecs[21] = mk(1'b0, 0, 0, 32'h0,   1, 32'h40,  mem_word(32'h40),  32'h44,       0);
        vecs[22] = mk(1'b1, 1, 0, 32'h0,   0, 32'h0,   32'h13,            32'h0,        1);
        vecs[23] = mk(1'b1, 0, 0, 32'h0,   1, 32'h0,   32'h0050_0093,     32'h4,        1);
        vecs[24] = mk(1'b1, 0, 0, 32'h0,   1, 32'h4,   mem_word(32'h4),   32'h8,        1);

        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < NVec; i++) begin
            drive(vecs[i].rst_n, vecs[i].stall, vecs[i].redir, vecs[i].rpc);
            chk_slot($sformatf("vec%0d", i), vecs[i].valid, vecs[i].pc, vecs[i].instr,
                     vecs[i].addr, vecs[i].en);
            // Wrap instance: boots at FFFF_FFFC, then wraps to 0.
            if (i == 2) chk("wrap boot addr", imem_addr2, 32'hFFFF_FFFC);
            if (i == 3) begin
                chk("wrap addr after", imem_addr2, 32'h0);
                chk("wrap pc_id", pc_id2, 32'hFFFF_FFFC);
                chk("wrap instr_id", instr_id2, mem_word(32'hFFFF_FFFC));
                chk("wrap valid_id", {31'b0, valid_id2}, 32'd1);
            end
            if (i == 4) chk("wrap addr next", imem_addr2, 32'h4);
        end

        // Reset asserted while holding a stalled instruction discards everything.
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        chk_slot("seq stall-enter", 1'b1, 32'h8, mem_word(32'h8), 32'hC, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        chk_slot("seq hold-reset", 1'b1, 32'h8, mem_word(32'h8), 32'hC, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        chk_slot("seq post-reset", 1'b0, 32'h0, 32'h13, 32'h0, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        chk_slot("seq restart", 1'b1, 32'h0, 32'h0050_0093, 32'h4, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
